// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-client RAM arbiter: default widths,
// sequencer state encoding and client index constants.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int WAIT_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD1  = 2'd2,
        RD2  = 2'd3
    } state_t;

    localparam logic CLI0 = 1'b0;
    localparam logic CLI1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker. On a tie the client that did
// not win last time is chosen; a lone request always wins.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    // Pick the winner from the request pair and the last-served pointer.
    always_comb begin
        valid  = |req;
        winner = CLI0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = CLI1;
        end
    end

endmodule

// File: rtl/ram_arbiter2.sv
// Two-client round-robin arbiter and sequencer for a single-port
// synchronous RAM with a shared bidirectional data bus.
// Optional macro RAM_ARB_WAIT_CNT_EN adds per-client wait counters.
module ram_arbiter2
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_read,
    output logic              ram_write,
    inout  wire  [DATA_W-1:0] ram_data
`ifdef RAM_ARB_WAIT_CNT_EN
    ,
    output logic [WAIT_W-1:0] wait_cnt0,
    output logic [WAIT_W-1:0] wait_cnt1
`endif
);

    state_t            state;
    state_t            state_n;
    logic              last;
    logic              owner;
    logic              winner;
    logic              pick_vld;
    logic              take;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;
    logic [DATA_W-1:0] cmd_wdata;

    rr_arb2 u_rr (
        .req    ({req1, req0}),
        .last   (last),
        .winner (winner),
        .valid  (pick_vld)
    );

    // Route the winning client's command fields.
    always_comb begin
        pick_we    = (winner == CLI1) ? we1    : we0;
        pick_addr  = (winner == CLI1) ? addr1  : addr0;
        pick_wdata = (winner == CLI1) ? wdata1 : wdata0;
    end

    // Next-state logic: requests are only looked at in IDLE.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    take    = 1'b1;
                    state_n = pick_we ? WR : RD1;
                end
            end
            WR:      state_n = IDLE;
            RD1:     state_n = RD2;
            RD2:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Round-robin pointer and read owner; client 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last  <= CLI1;
            owner <= CLI0;
        end else if (take) begin
            last  <= winner;
            owner <= winner;
        end
    end

    // Write data is only consumed in WR, so it needs no reset.
    always_ff @(posedge clock) begin
        if (take) begin
            cmd_wdata <= pick_wdata;
        end
    end

    // Registered grants and RAM strobes, derived from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ram_cs    <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
        end else begin
            gnt0      <= take && (winner == CLI0);
            gnt1      <= take && (winner == CLI1);
            ram_cs    <= (state_n != IDLE);
            ram_write <= (state_n == WR);
            ram_read  <= (state_n == RD1) || (state_n == RD2);
            if (take) begin
                ram_addr <= pick_addr;
            end
        end
    end

    // Capture RAM output at the end of RD2 for the owning client only.
    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= (state == RD2) && (owner == CLI0);
            rvalid1 <= (state == RD2) && (owner == CLI1);
            if ((state == RD2) && (owner == CLI0)) begin
                rdata0 <= ram_data;
            end
            if ((state == RD2) && (owner == CLI1)) begin
                rdata1 <= ram_data;
            end
        end
    end

    // The bus is driven only during the WR cycle; otherwise the RAM owns it.
    assign ram_data = (state == WR) ? cmd_wdata : {DATA_W{1'bz}};

`ifdef RAM_ARB_WAIT_CNT_EN
    // Saturating count of cycles each request waits without a grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt0 <= '0;
            wait_cnt1 <= '0;
        end else begin
            if (gnt0) begin
                wait_cnt0 <= '0;
            end else if (req0 && (wait_cnt0 != {WAIT_W{1'b1}})) begin
                wait_cnt0 <= wait_cnt0 + 1'b1;
            end
            if (gnt1) begin
                wait_cnt1 <= '0;
            end else if (req1 && (wait_cnt1 != {WAIT_W{1'b1}})) begin
                wait_cnt1 <= wait_cnt1 + 1'b1;
            end
        end
    end
`else
    // Wait counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ram_arbiter2.sv
// Directed bench for ram_arbiter2 with a behavioural 1024x8 RAM on the
// shared bus and a scoreboard queue of expected read returns.
module tb_ram_arbiter2;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_addr;
    logic          ram_cs, ram_read, ram_write;
    wire  [DW-1:0] ram_data;
`ifdef RAM_ARB_WAIT_CNT_EN
    logic [7:0]    wait_cnt0, wait_cnt1;
`endif

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic          c;
        logic [DW-1:0] d;
    } exp_t;
    exp_t sbq[$];

    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] ram_dout = '0;
    logic          ram_oe   = 1'b0;

    always #5 clock = ~clock;

    ram_arbiter2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_read(ram_read),
        .ram_write(ram_write), .ram_data(ram_data)
`ifdef RAM_ARB_WAIT_CNT_EN
        , .wait_cnt0(wait_cnt0), .wait_cnt1(wait_cnt1)
`endif
    );

    // Synchronous RAM: output registered on a read strobe, driven next cycle.
    always @(posedge clock) begin
        if (ram_cs && ram_write) mem[ram_addr] <= ram_data;
        if (ram_cs && ram_read)  ram_dout <= mem[ram_addr];
        ram_oe <= ram_cs && ram_read;
    end
    assign ram_data = ram_oe ? ram_dout : {DW{1'bz}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus invariants, every cycle.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            check("rw_excl", 32'(ram_read & ram_write), 32'd0);
            check("one_gnt", 32'(gnt0 & gnt1), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic c, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (c == 1'b0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic wait_gnt(input logic c, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ((c == 1'b0 && gnt0) || (c == 1'b1 && gnt1)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_check(input string tag, input logic c, input logic [DW-1:0] d);
        exp_t e;
        if (sbq.size() == 0) begin
            check({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check({tag, "_cli"}, 32'(c), 32'(e.c));
            check({tag, "_data"}, 32'(d), 32'(e.d));
        end
    endtask

    task automatic do_write(input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic ok;
        drive(c, 1'b1, 1'b1, a, d);
        wait_gnt(c, ok);
        if (ok) begin
            check("wr_other_gnt", 32'(c ? gnt0 : gnt1), 32'd0);
            check("wr_cs", 32'(ram_cs), 32'd1);
            check("wr_write", 32'(ram_write), 32'd1);
            check("wr_read", 32'(ram_read), 32'd0);
            check("wr_addr", 32'(ram_addr), 32'(a));
            check("wr_bus", 32'(ram_data), 32'(d));
            ref_mem[a] = d;
        end
        drive(c, 1'b0, 1'b0, '0, '0);
        tick();
        check("wr_after_cs", 32'(ram_cs), 32'd0);
    endtask

    task automatic do_read(input logic c, input logic [AW-1:0] a);
        logic ok;
        logic [DW-1:0] other_rd;
        other_rd = c ? rdata0 : rdata1;
        drive(c, 1'b0, 1'b0, a, '0);
        if (c == 1'b0) req0 = 1'b1; else req1 = 1'b1;
        wait_gnt(c, ok);
        drive(c, 1'b0, 1'b0, '0, '0);
        if (ok) begin
            sbq.push_back('{c, ref_mem[a]});
            check("rd1_read", 32'(ram_read), 32'd1);
            check("rd1_write", 32'(ram_write), 32'd0);
            check("rd1_addr", 32'(ram_addr), 32'(a));
            tick();
            check("rd2_read", 32'(ram_read), 32'd1);
            check("rd2_rvalid", 32'(rvalid0 | rvalid1), 32'd0);
            tick();
            check("rd_rvalid_own", 32'(c ? rvalid1 : rvalid0), 32'd1);
            check("rd_rvalid_other", 32'(c ? rvalid0 : rvalid1), 32'd0);
            check("rd_strobe_off", 32'(ram_read), 32'd0);
            pop_check("rd", c, c ? rdata1 : rdata0);
            check("rd_other_hold", 32'(c ? rdata0 : rdata1), 32'(other_rd));
            tick();
            check("rd_rvalid_clear", 32'(rvalid0 | rvalid1), 32'd0);
        end
    endtask

    initial begin
        logic ok;
        logic exp_c;
        int   last_g;
        int   ng;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset state.
        tick();
        tick();
        check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        check("rst_strobes", 32'({ram_cs, ram_read, ram_write}), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Basic write then read by the other client.
        do_write(1'b0, 10'h005, 8'hA5);
        do_read(1'b1, 10'h005);

        // Top address, no wrap.
        do_write(1'b0, 10'h3FF, 8'hFF);
        do_read(1'b1, 10'h3FF);

        // Contention: both clients read continuously.
        do_write(1'b0, 10'h020, 8'h11);
        do_write(1'b1, 10'h021, 8'h22);
        drive(1'b0, 1'b1, 1'b0, 10'h020, '0);
        drive(1'b1, 1'b1, 1'b0, 10'h021, '0);
        exp_c  = 1'b0;
        last_g = -100;
        ng     = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            tick();
            if (gnt0 | gnt1) begin
                check("cont_order", 32'(gnt1), 32'(exp_c));
                if (ng > 0) check("cont_spacing", 32'(cyc - last_g), 32'd3);
                sbq.push_back('{gnt1, gnt1 ? ref_mem[10'h021] : ref_mem[10'h020]});
                exp_c  = ~exp_c;
                last_g = cyc;
                ng++;
            end
            if (rvalid0 | rvalid1) pop_check("cont", rvalid1, rvalid1 ? rdata1 : rdata0);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            if (rvalid0 | rvalid1) pop_check("drain", rvalid1, rvalid1 ? rdata1 : rdata0);
        end
        check("cont_count", 32'(ng), 32'd6);
        check("sbq_empty", 32'(sbq.size()), 32'd0);

        // Reset during RD1: read discarded.
        drive(1'b0, 1'b1, 1'b0, 10'h005, '0);
        wait_gnt(1'b0, ok);
        check("rstrd_in_rd1", 32'(ram_read), 32'd1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        check("rstrd_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("rstrd_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        check("rstrd_strobes", 32'({ram_cs, ram_read, ram_write}), 32'd0);
        check("rstrd_addr", 32'(ram_addr), 32'd0);
        check("rstrd_rdata", 32'({rdata1, rdata0}), 32'd0);
        tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            check("rstrd_no_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        end

        // Reset during WR: write still commits.
        drive(1'b0, 1'b1, 1'b1, 10'h010, 8'h3C);
        wait_gnt(1'b0, ok);
        check("rstwr_write", 32'(ram_write), 32'd1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        ref_mem[10'h010] = 8'h3C;
        tick();
        check("rstwr_strobes", 32'({ram_cs, ram_write}), 32'd0);
        reset = 1'b0;
        tick();
        do_read(1'b1, 10'h010);

`ifdef RAM_ARB_WAIT_CNT_EN
        // Wait counter of client 1 while client 0 reads.
        drive(1'b0, 1'b1, 1'b0, 10'h3FF, '0);
        wait_gnt(1'b0, ok);
        check("wc0_at_gnt", 32'(wait_cnt0), 32'd1);
        check("wc1_idle", 32'(wait_cnt1), 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 10'h005, '0);
        tick();
        check("wc1_rd2", 32'(wait_cnt1), 32'd1);
        check("wc0_clear", 32'(wait_cnt0), 32'd0);
        tick();
        check("wc1_idle2", 32'(wait_cnt1), 32'd2);
        check("wc_rdata0", 32'(rdata0), 32'(ref_mem[10'h3FF]));
        tick();
        check("wc_gnt1", 32'(gnt1), 32'd1);
        check("wc1_at_gnt", 32'(wait_cnt1), 32'd3);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        check("wc1_cleared", 32'(wait_cnt1), 32'd0);
        tick();
        check("wc_rdata1", 32'(rdata1), 32'(ref_mem[10'h005]));
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter2.md
Name: ram_arbiter2

Overview:
Two-requester round-robin arbiter and sequencer for the single-port synchronous 1024x8 RAM with a bidirectional data bus.
- Accepts independent read/write requests from two clients.
- Serialises them onto the RAM's addr/cs/read/write pins.
- Owns the tri-state drive of the shared data bus.
- Returns read data to the winning client.
- Sits directly between client logic and the RAM instance; the RAM's pins connect 1:1 to the ram_* ports.

Parameters:
ADDR_W, 10, RAM address width (1024 words)
DATA_W, 8, RAM data width

Ports:
clock  input  1  single system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req0  input  1  client 0 request, held until gnt0 seen
we0  input  1  client 0: 1=write, 0=read; stable while req0
addr0  input  ADDR_W  client 0 address
wdata0  input  DATA_W  client 0 write data
gnt0  output  1  one-cycle grant pulse to client 0
rvalid0  output  1  one-cycle read-data-valid to client 0
rdata0  output  DATA_W  client 0 read data, valid when rvalid0
req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1  same as client 0, for client 1
ram_addr  output  ADDR_W  RAM address
ram_cs  output  1  RAM chip select
ram_read  output  1  RAM read strobe
ram_write  output  1  RAM write strobe
ram_data  inout  DATA_W  RAM bidirectional data bus

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; gnt*/rvalid*/ram_cs/ram_read/ram_write=0; ram_addr=0; rdata*=0.
  - ram_data released to Z; rr pointer last=1, so client 0 wins the first tie.
- FSM states: IDLE, WR, RD1, RD2. All outputs are registered except the ram_data tri-state enable (enable = state==WR).
- IDLE: no RAM strobes.
  - If any req is high, latch the winner's we/addr/wdata into command registers.
  - Pulse that client's gnt for the next cycle; go to WR (we=1) or RD1 (we=0). Otherwise stay.
- Arbitration:
  - Only req0 -> client 0; only req1 -> client 1.
  - Both -> the client not equal to last; last updates to the winner.
  - req is sampled only in IDLE; req level in other states is ignored.
- Client handshake:
  - Client holds req/we/addr/wdata stable until it samples gnt=1 at a posedge, then may drop or change them.
  - req still high in the following IDLE is a new request.
- WR (1 cycle):
  - ram_cs=1, ram_write=1, ram_read=0, ram_addr=cmd addr.
  - Arbiter drives ram_data=cmd wdata; RAM writes at the end-of-cycle edge.
  - Next state IDLE.
- RD1 (1 cycle):
  - ram_cs=1, ram_read=1, ram_write=0, ram_addr=cmd addr; ram_data Z.
  - RAM registers its output at the edge. Next RD2.
- RD2 (1 cycle):
  - ram_cs=1, ram_read=1; RAM drives ram_data.
  - At the edge, capture ram_data into rdata of the owner; rvalid of the owner =1 for exactly the next cycle (IDLE). Next IDLE.
- Timing:
  - Write occupancy: 2 cycles (IDLE+WR).
  - Read occupancy: 3 cycles.
  - Read latency: gnt in cycle N, rvalid in cycle N+2.
  - Back-to-back contention alternates clients.
- Invariants:
  - ram_read and ram_write are never both 1.
  - Arbiter never drives ram_data while ram_read=1.
  - Only one gnt is high per cycle.
  - rdata of the non-owner holds its previous value.
- Reset mid-operation:
  - A write whose WR cycle ends on the reset edge is committed (RAM sampled strobes that edge).
  - An in-flight read is discarded, with no rvalid.
  - Pending grants are lost; clients must re-request.

Optional Feature:
RAM_ARB_WAIT_CNT_EN:
- Defined:
  - Adds outputs wait_cnt0 and wait_cnt1 (8 bits each).
  - Each counts cycles its req is high without gnt, saturating at 255.
  - Each clears to 0 on that client's gnt and on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package ram_arb_pkg holds:
  - ADDR_W/DATA_W defaults.
  - State enum typedef (IDLE, WR, RD1, RD2).
  - Client-index constants (CLI0=0, CLI1=1).
- One sub-module, rr_arb2: combinational two-way round-robin picker (req[1:0], last -> winner, valid). The FSM and pointer register stay in ram_arbiter2.

Test Plan:
- Reset, then req0 write addr=0x005 wdata=0xA5 -> gnt0 next cycle; WR cycle shows ram_cs=1, ram_write=1, ram_data=0xA5; no gnt1.
- After that write, req1 read addr=0x005 -> gnt1 at N, ram_read high N..N+1, rvalid1=1 with rdata1=0xA5 at N+2; rvalid0 stays 0.
- req0 and req1 both held high continuously with reads -> grants alternate 0,1,0,1 with 3-cycle spacing; first grant to client 0.
- Write 0xFF to 0x3FF, then read 0x3FF -> 0xFF; check ram_addr upper bound with no wrap.
- Assert reset during RD1 -> no rvalid, all outputs 0, ram_data Z; assert reset in the WR cycle for 0x010=0x3C, then read 0x010 -> 0x3C.
- With RAM_ARB_WAIT_CNT_EN: hold req1 high while client 0 is mid-read -> wait_cnt1 increments each stalled cycle, clears to 0 the cycle after gnt1; without the macro the bench compiles with no such ports.
